// File: rtl/bpm_digit_splitter.sv
// Binary BPM to three decimal digits via repeated subtraction (IDLE/HUND/TENS/ONES).
// Optional leading-zero blank flags: define BPM_LEADING_ZERO_BLANK_EN.
module bpm_digit_splitter #(
  parameter int BPM_WIDTH = 10,
  parameter int MAX_VALUE = 999
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BPM_WIDTH-1:0] bpm,
  input  logic                 bpm_valid,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           digit_hundreds,
  output logic [3:0]           digit_tens,
  output logic [3:0]           digit_ones,
  output logic                 saturated,
  output logic [2:0]           digit_blank
);

  localparam logic [BPM_WIDTH-1:0] LP_MAX = BPM_WIDTH'(MAX_VALUE);
  localparam logic [BPM_WIDTH-1:0] LP_100 = BPM_WIDTH'(100);
  localparam logic [BPM_WIDTH-1:0] LP_10  = BPM_WIDTH'(10);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HUND,
    S_TENS,
    S_ONES
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [BPM_WIDTH-1:0] r_work, w_work_nxt;
  logic [3:0]           r_hund, w_hund_nxt;
  logic [3:0]           r_tens, w_tens_nxt;
  logic                 r_sat_pend, w_sat_pend_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic [3:0]           r_dig_h, r_dig_t, r_dig_o;
  logic                 r_sat;
  logic                 w_over;

  assign w_over = (bpm > LP_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_work_nxt     = r_work;
    w_hund_nxt     = r_hund;
    w_tens_nxt     = r_tens;
    w_sat_pend_nxt = r_sat_pend;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bpm_valid) begin
          w_work_nxt     = w_over ? LP_MAX : bpm;
          w_sat_pend_nxt = w_over;
          w_hund_nxt     = '0;
          w_tens_nxt     = '0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = S_HUND;
        end
      end
      S_HUND: begin
        if (r_work >= LP_100) begin
          w_work_nxt = r_work - LP_100;
          w_hund_nxt = r_hund + 4'd1;
        end else begin
          w_state_nxt = S_TENS;
        end
      end
      S_TENS: begin
        if (r_work >= LP_10) begin
          w_work_nxt = r_work - LP_10;
          w_tens_nxt = r_tens + 4'd1;
        end else begin
          w_state_nxt = S_ONES;
        end
      end
      S_ONES: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_work     <= '0;
      r_hund     <= '0;
      r_tens     <= '0;
      r_sat_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_work     <= w_work_nxt;
      r_hund     <= w_hund_nxt;
      r_tens     <= w_tens_nxt;
      r_sat_pend <= w_sat_pend_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Published results only move on the ONES edge so the display can sample any cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dig_h <= '0;
      r_dig_t <= '0;
      r_dig_o <= '0;
      r_sat   <= 1'b0;
    end else if (r_state == S_ONES) begin
      r_dig_h <= r_hund;
      r_dig_t <= r_tens;
      r_dig_o <= r_work[3:0];
      r_sat   <= r_sat_pend;
    end
  end

`ifdef BPM_LEADING_ZERO_BLANK_EN
  logic [2:0] r_blank;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blank <= '0;
    end else if (r_state == S_ONES) begin
      r_blank <= {(r_hund == 4'd0), (r_hund == 4'd0) && (r_tens == 4'd0), 1'b0};
    end
  end

  assign digit_blank = r_blank;
`else
  assign digit_blank = '0;
`endif

  assign busy           = r_busy;
  assign done           = r_done;
  assign digit_hundreds = r_dig_h;
  assign digit_tens     = r_dig_t;
  assign digit_ones     = r_dig_o;
  assign saturated      = r_sat;

endmodule

// File: tb/tb_bpm_digit_splitter.sv
// Directed + randomized check of bpm_digit_splitter against a divide/modulo reference model.
// Honours BPM_LEADING_ZERO_BLANK_EN the same way as the design build.
module tb_bpm_digit_splitter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] bpm = '0;
  logic       bpm_valid = 1'b0;
  logic       busy, done, saturated;
  logic [3:0] digit_hundreds, digit_tens, digit_ones;
  logic [2:0] digit_blank;

  int vectors = 0;
  int miscompares = 0;
  int ph = 0, pt = 0, po = 0, psat = 0, pblank = 0;

  bpm_digit_splitter #(.BPM_WIDTH(10), .MAX_VALUE(999)) dut (
    .clk            (clk),
    .reset          (reset),
    .bpm            (bpm),
    .bpm_valid      (bpm_valid),
    .busy           (busy),
    .done           (done),
    .digit_hundreds (digit_hundreds),
    .digit_tens     (digit_tens),
    .digit_ones     (digit_ones),
    .saturated      (saturated),
    .digit_blank    (digit_blank)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain decimal arithmetic on the clamped value.
  function automatic void model(input int b, output int h, output int t, output int o,
                                output int sat, output int lat, output int blank);
    int v;
    v   = (b > 999) ? 999 : b;
    sat = (b > 999) ? 1 : 0;
    h   = v / 100;
    t   = (v / 10) % 10;
    o   = v % 10;
    lat = h + t + 3;
`ifdef BPM_LEADING_ZERO_BLANK_EN
    blank = ((h == 0) ? 4 : 0) + ((h == 0 && t == 0) ? 2 : 0);
`else
    blank = 0;
`endif
  endfunction

  // Called just after the accepting edge. Optionally injects a request while busy
  // (ign_at > 0) and optionally chains a new request on the done cycle.
  task automatic follow(input int v, input int ign_at, input int ign_v,
                        input bit chain, input int chain_v);
    int h, t, o, sat, lat, blank, n;
    bit got;
    model(v, h, t, o, sat, lat, blank);
    bpm_valid = 1'b0;
    bpm = 10'($urandom_range(0, 1023));
    n = 0;
    got = 0;
    chk("busy_after_accept", busy, 1);
    while (n < 40 && !got) begin
      if (n == ign_at && ign_at > 0) begin
        bpm = 10'(ign_v);
        bpm_valid = 1'b1;
      end else if (n == ign_at + 1 && ign_at > 0) begin
        bpm_valid = 1'b0;
      end
      tick();
      n++;
      if (done === 1'b1) begin
        got = 1;
      end else if (n == 2 || n == lat - 1) begin
        chk("hold_busy", busy, 1);
        chk("hold_digits", {digit_hundreds, digit_tens, digit_ones}, {4'(ph), 4'(pt), 4'(po)});
        chk("hold_sat", saturated, psat);
      end
    end
    chk("latency", got ? n : 99, lat);
    chk("digit_h", digit_hundreds, h);
    chk("digit_t", digit_tens, t);
    chk("digit_o", digit_ones, o);
    chk("saturated", saturated, sat);
    chk("blank", digit_blank, blank);
    chk("busy_at_done", busy, 0);
    ph = h; pt = t; po = o; psat = sat; pblank = blank;
    bpm_valid = chain;
    bpm = 10'(chain_v);
    tick();
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, chain ? 1 : 0);
  endtask

  task automatic convert(input int v, input int ign_at, input int ign_v);
    bpm = 10'(v);
    bpm_valid = 1'b1;
    tick();
    follow(v, ign_at, ign_v, 1'b0, 0);
  endtask

  initial begin
    int dcount;
    int r, ia, cv;
    bit ch;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_digits", {digit_hundreds, digit_tens, digit_ones}, 0);
    chk("rst_sat", saturated, 0);
    chk("rst_blank", digit_blank, 0);
    reset = 1'b1;
    tick();

    // Abort mid-HUND of 500.
    bpm = 10'd500;
    bpm_valid = 1'b1;
    tick();
    bpm_valid = 1'b0;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_digits", {digit_hundreds, digit_tens, digit_ones}, 0);
    chk("abort_sat", saturated, 0);
    tick();
    tick();
    reset = 1'b1;
    dcount = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done === 1'b1) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    ph = 0; pt = 0; po = 0; psat = 0; pblank = 0;

    convert(0, 0, 0);
    convert(72, 0, 0);
    convert(999, 5, 50);
    convert(1023, 0, 0);
    convert(100, 0, 0);
    convert(999, 0, 0);
    convert(1000, 0, 0);

    // Request on the done cycle is accepted.
    bpm = 10'd60;
    bpm_valid = 1'b1;
    tick();
    follow(60, 0, 0, 1'b1, 120);
    follow(120, 0, 0, 1'b0, 0);

    for (int k = 0; k < 24; k++) begin
      r  = int'($urandom_range(0, 1023));
      ia = ($urandom_range(0, 1) == 1) ? 1 : 0;
      ch = ($urandom_range(0, 3) == 0);
      cv = int'($urandom_range(0, 1023));
      bpm = 10'(r);
      bpm_valid = 1'b1;
      tick();
      follow(r, ia, int'($urandom_range(0, 1023)), ch, cv);
      if (ch) follow(cv, 0, 0, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bpm_digit_splitter.md
Name: bpm_digit_splitter

Overview:
Converts a binary heart-rate value (BPM) into three decimal digits (hundreds, tens, ones) for the on-screen readout. Each digit feeds the per-digit sprite-coordinate lookup stage directly downstream. Conversion is a multi-cycle repeated-subtraction FSM, started by a one-cycle request pulse. Output digits are held stable between conversions so the display pipeline can sample them on any cycle.

Parameters:
BPM_WIDTH, 10, width of the binary input value
MAX_VALUE, 999, saturation ceiling; must be at most 999 and fit in BPM_WIDTH bits

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
bpm  input  BPM_WIDTH  binary BPM value; sampled only on an accepted request
bpm_valid  input  1  one-cycle request pulse; starts a conversion
busy  output  1  high from the cycle after acceptance until done is pulsed
done  output  1  one-cycle pulse; new digits are valid on this cycle
digit_hundreds  output  4  hundreds digit, 0-9
digit_tens  output  4  tens digit, 0-9
digit_ones  output  4  ones digit, 0-9
saturated  output  1  high if the last accepted bpm exceeded MAX_VALUE
digit_blank  output  3  per-digit blank flags {hundreds, tens, ones}; see Optional Feature

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - busy=0, done=0, saturated=0, digit_blank=3'b000.
  - All digits = 0.
  - Internal work register and counters cleared.
- FSM states: IDLE, HUND, TENS, ONES.
- IDLE:
  - If bpm_valid=1: work <= min(bpm, MAX_VALUE); hundreds/tens counters <= 0; next state HUND; busy <= 1.
  - The saturation result is captured internally and published at done.
- HUND:
  - If work >= 100: work -= 100 and hundreds counter +1; stay in HUND.
  - Otherwise go to TENS.
- TENS:
  - If work >= 10: work -= 10 and tens counter +1; stay in TENS.
  - Otherwise go to ONES.
- ONES:
  - Register outputs in one edge: digit_hundreds, digit_tens, digit_ones <= work[3:0], saturated, digit_blank.
  - Same edge: done <= 1, busy <= 0, next state IDLE.
- done is registered. It is high for exactly one cycle and deasserts on the following edge.
- Latency: with H = hundreds digit and T = tens digit, done is high (H+T+3) cycles after the edge that sampled bpm_valid.
  - Minimum is 3 (bpm=0). Maximum is 21 (value 999).
- Output digits and saturated change only on the ONES edge. They hold their previous values throughout busy.
- bpm_valid while busy=1 (HUND/TENS/ONES) is ignored. No queueing, and the in-flight conversion is unaffected.
- bpm_valid on the same cycle done=1 (FSM already in IDLE) is accepted normally.
- bpm_valid held high for several cycles starts a new conversion on each IDLE cycle in which it is high. Back-to-back requests are legal.
- bpm changing while busy has no effect; the value is latched at acceptance.
- Saturation: any bpm > MAX_VALUE converts as MAX_VALUE with saturated=1. bpm == MAX_VALUE gives saturated=0.
- Reset asserted mid-conversion aborts immediately. Outputs return to reset values and no done is produced.
- Arithmetic: work is BPM_WIDTH bits, compared unsigned. Counters are 4 bits and never exceed 9 by construction.

Optional Feature:
Macro BPM_LEADING_ZERO_BLANK_EN.
- Defined: at the ONES edge, digit_blank is computed as follows.
  - [2] = (hundreds digit == 0).
  - [1] = (hundreds digit == 0 && tens digit == 0).
  - [0] = 0; the ones digit is never blanked, so 0 displays as "0".
- The downstream renderer suppresses sprites whose blank flag is set.
- Not defined: digit_blank is tied to 3'b000 and all three digits always display. No blanking logic is synthesized.

Test Plan:
- Reset asserted mid-HUND of bpm=500 -> outputs immediately zero, busy=0, no done pulse; then bpm=0 -> done after 3 cycles, digits 0/0/0, digit_blank=3'b110 (with _EN).
- bpm=72 pulse -> done exactly 10 cycles after acceptance; digits 0/7/2; saturated=0; digit_blank=3'b100 (with _EN), 3'b000 (without).
- bpm=999 -> done after 21 cycles, digits 9/9/9; a second pulse bpm=50 issued at cycle 5 is ignored and the digits stay 9/9/9.
- bpm=1023 -> digits 9/9/9, saturated=1, 21-cycle latency; following bpm=100 -> digits 1/0/0, saturated=0, done after 4 cycles.
- bpm=60 pulse, then bpm=120 pulse on the done cycle -> 120 accepted; digits hold 0/6/0 while busy, then update to 1/2/0 with done 6 cycles later.
